// File: rtl/garoa_cal_pkg.sv
// GF(2^8) multiplier shared constants, FSM state type and the xtime helper.
package garoa_cal_pkg;

    localparam int          GF_W         = 8;
    localparam logic [7:0]  DEFAULT_POLY = 8'h1B;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Multiply by the field generator: shift left, fold x^8 back in via poly.
    function automatic logic [GF_W-1:0] gf_xtime(input logic [GF_W-1:0] a,
                                                 input logic [GF_W-1:0] poly);
        return {a[GF_W-2:0], 1'b0} ^ (a[GF_W-1] ? poly : '0);
    endfunction

endpackage

// File: rtl/garoa_cal_if.sv
// Request/result bundle of the GF(2^8) multiplier: start with operands, busy/done with product.
interface garoa_cal_if;
    import garoa_cal_pkg::*;

    logic            start;
    logic [GF_W-1:0] x;
    logic [GF_W-1:0] y;
    logic            busy;
    logic            done;
    logic [GF_W-1:0] d;

    modport master (output start, x, y, input  busy, done, d);
    modport slave  (input  start, x, y, output busy, done, d);

endinterface

// File: rtl/garoa_cal_gf_xtime.sv
// gf_xtime: one GF(2^8) doubling step, a*x mod (x^8 + POLY).
// Latency: combinational.
// Backpressure: none, pure function of its input.
module gf_xtime
    import garoa_cal_pkg::*;
#(
    parameter logic [GF_W-1:0] POLY = DEFAULT_POLY
) (
    input  logic [GF_W-1:0] a,
    output logic [GF_W-1:0] z
);

    assign z = garoa_cal_pkg::gf_xtime(a, POLY);

endmodule

// File: rtl/garoa_cal.sv
// garoa_cal: GF(2^8) multiplier d = x*y mod (x^8 + POLY); GAROA_CAL_FAST_EN selects the one-cycle build.
// Latency: 9 cycles start->done serial (busy for 8), 1 cycle in the fast build (busy stays 0).
// Backpressure: start is only accepted while busy=0, including the done cycle; ignored during rst.
module garoa_cal
    import garoa_cal_pkg::*;
#(
    parameter logic [GF_W-1:0] POLY = DEFAULT_POLY
) (
    input  logic       clk,
    input  logic       rst,
    garoa_cal_if.slave bus
);

`ifdef GAROA_CAL_FAST_EN

    // Unrolled MSB-first Horner chain; stage[i+1] has consumed y[7-i].
    logic [GF_W-1:0] stage [0:GF_W];
    logic [GF_W-1:0] stage_xt [0:GF_W-1];

    assign stage[0] = '0;

    for (genvar i = 0; i < GF_W; i++) begin : g_stage
        gf_xtime #(.POLY(POLY)) u_xtime (.a(stage[i]), .z(stage_xt[i]));
        assign stage[i+1] = stage_xt[i] ^ (bus.y[GF_W-1-i] ? bus.x : '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.done <= 1'b0;
            bus.d    <= '0;
        end else begin
            bus.done <= bus.start;
            if (bus.start) begin
                bus.d <= stage[GF_W];
            end
        end
    end

    assign bus.busy = 1'b0;

`else

    state_t          state;
    state_t          state_nxt;
    logic [2:0]      cnt;
    logic [GF_W-1:0] acc;
    logic [GF_W-1:0] acc_xt;
    logic [GF_W-1:0] acc_nxt;
    logic [GF_W-1:0] x_lat;
    logic [GF_W-1:0] y_lat;
    logic            last_iter;

    gf_xtime #(.POLY(POLY)) u_xtime (.a(acc), .z(acc_xt));

    // y_lat shifts left so its MSB is always the current Horner bit.
    assign acc_nxt   = acc_xt ^ (y_lat[GF_W-1] ? x_lat : '0);
    assign last_iter = (cnt == 3'd7);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (last_iter) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state == RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            acc      <= '0;
            x_lat    <= '0;
            y_lat    <= '0;
            bus.d    <= '0;
            bus.done <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            if (state == IDLE) begin
                if (bus.start) begin
                    x_lat <= bus.x;
                    y_lat <= bus.y;
                    acc   <= '0;
                    cnt   <= '0;
                end
            end else begin
                acc   <= acc_nxt;
                y_lat <= {y_lat[GF_W-2:0], 1'b0};
                cnt   <= cnt + 3'd1;
                if (last_iter) begin
                    bus.d    <= acc_nxt;
                    bus.done <= 1'b1;
                end
            end
        end
    end

`endif

endmodule

// File: tb/tb_garoa_cal.sv
// Bench for garoa_cal: directed vectors, abort/ignore/back-to-back cases and random products vs a schoolbook model.
module tb_garoa_cal;

    localparam logic [7:0] POLY = 8'h1B;
`ifdef GAROA_CAL_FAST_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 9;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    garoa_cal_if bus ();

    garoa_cal #(.POLY(POLY)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Full 15-bit carry-less product, then long division by x^8 + POLY.
    function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p = '0;
        logic [15:0] m = {7'b0, 1'b1, POLY};
        for (int i = 0; i < 8; i++)
            if (b[i]) p ^= ({8'b0, a} << i);
        for (int i = 15; i >= 8; i--)
            if (p[i]) p ^= (m << (i - 8));
        return p[7:0];
    endfunction

    task automatic launch(input logic [7:0] xa, input logic [7:0] ya);
        bus.start = 1'b1;
        bus.x     = xa;
        bus.y     = ya;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 1;
        while (!bus.done && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic do_op(input string tag, input logic [7:0] xa, input logic [7:0] ya,
                         input logic [7:0] exp);
        int n;
        launch(xa, ya);
        wait_done(n);
        chk({tag, "_lat"}, n, LAT);
        chk(tag, bus.d, exp);
    endtask

    initial begin
        int n;
        int pulses;
        logic [7:0] ra, rb, held;

        bus.start = 1'b0;
        bus.x     = '0;
        bus.y     = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_d",    bus.d,    8'h00);
        rst = 1'b0;
        @(negedge clk);

        // Directed vectors, including an inverse pair.
        launch(8'h56, 8'h12);
        chk("busy_c1", bus.busy, (LAT > 1) ? 1'b1 : 1'b0);
        wait_done(n);
        chk("v56x12_lat", n, LAT);
        chk("v56x12", bus.d, 8'hBB);
        @(negedge clk);
        chk("done_pulse_width", bus.done, 1'b0);
        do_op("v46x4c", 8'h46, 8'h4C, 8'h35);
        do_op("v02x4c", 8'h02, 8'h4C, 8'h98);
        do_op("v13x5c", 8'h13, 8'h5C, 8'h53);
        do_op("v53xca", 8'h53, 8'hCA, 8'h01);
        do_op("zero_x", 8'h00, 8'h9D, 8'h00);
        do_op("one_x",  8'h01, 8'h7E, 8'h7E);

        // d holds between pulses.
        repeat (4) @(negedge clk);
        chk("d_hold", bus.d, 8'h7E);

`ifndef GAROA_CAL_FAST_EN
        // Start while busy must not disturb the operation in flight.
        launch(8'h56, 8'h12);
        @(negedge clk);
        @(negedge clk);
        bus.start = 1'b1;
        bus.x     = 8'hFF;
        bus.y     = 8'hFF;
        @(negedge clk);
        bus.start = 1'b0;
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            if (bus.done) begin
                pulses++;
                held = bus.d;
            end
            @(negedge clk);
        end
        chk("ignore_pulses", pulses, 1);
        chk("ignore_d", held, 8'hBB);
`endif

        // Reset in cycle 4 aborts without a done pulse.
        launch(8'h46, 8'h4C);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("abort_busy", bus.busy, 1'b0);
        chk("abort_done", bus.done, 1'b0);
        chk("abort_d",    bus.d,    8'h00);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.done) pulses++;
            @(negedge clk);
        end
        chk("abort_no_done", pulses, 0);
        chk("abort_d_held", bus.d, 8'h00);
        do_op("post_rst", 8'h00, 8'hAB, 8'h00);

        // Back-to-back: new start issued in the done cycle.
        launch(8'h13, 8'h5C);
        wait_done(n);
        chk("b2b_first", bus.d, 8'h53);
        launch(8'h01, 8'hE5);
        wait_done(n);
        chk("b2b_lat", n, LAT);
        chk("b2b_d", bus.d, 8'hE5);

        // Random products, chained back-to-back half the time; odd ones swap operands.
        for (int k = 0; k < 40; k++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 0) @(negedge clk);
            if (k % 2 == 1) do_op("rand_swap", rb, ra, ref_mul(ra, rb));
            else            do_op("rand",      ra, rb, ref_mul(ra, rb));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/garoa_cal.md
GAROA_CAL -- requirements
Module: garoa_cal

Interface
REQ-001 SHALL have parameter POLY, default 8'h1B, low 8 bits of the reduction polynomial (x^8 is implicit; the default gives 0x11B).
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit, reset; synchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit, request to begin a multiplication.
REQ-005 SHALL have port x, input, 8 bits, multiplicand, sampled when start is accepted.
REQ-006 SHALL have port y, input, 8 bits, multiplier, sampled when start is accepted.
REQ-007 SHALL have port busy, output, 1 bit, high while an operation is in progress.
REQ-008 SHALL have port done, output, 1 bit, one-cycle pulse when d is updated.
REQ-009 SHALL have port d, output, 8 bits, the GF(2^8) product x*y mod (x^8 + POLY).

Function
REQ-010 SHALL compute carry-less multiplication with modular reduction: add = XOR; xtime(a) = (a<<1) XOR (a[7] ? POLY : 0).
REQ-011 SHALL accept start only when busy=0; start while busy=1 SHALL be ignored and SHALL NOT alter inputs latched for the operation in flight.
REQ-012 SHALL use serial mode: FSM IDLE->RUN on an accepted start; RUN runs exactly 8 iterations (MSB-first Horner: acc = xtime(acc) XOR (y[i] ? x : 0), i=7..0); then return to IDLE.
REQ-013 SHALL in serial mode set busy the cycle after accept for 8 cycles; the cycle after the last iteration, d is updated, done=1 for 1 cycle and busy=0; latency start->done = 9 cycles.
REQ-014 SHALL accept start in the same cycle done is high (back-to-back operation).
REQ-015 SHALL hold d stable between done pulses.
REQ-016 SHALL produce operands equal to 0 -> d=0; x=1 -> d=y; multiplication SHALL be commutative.

Reset
REQ-017 SHALL, while rst=1 at a clock edge, set FSM=IDLE, busy=0, done=0, d=8'h00, internal accumulator/counter=0.
REQ-018 SHALL abort an operation when reset arrives mid-operation, with no done pulse; start SHALL be ignored while rst=1.

Configuration
REQ-019 SHALL compile GAROA_CAL_FAST_EN, when defined, as a fully combinational 8-stage product registered once: done and d are updated 1 cycle after an accepted start, and busy SHALL stay 0.
REQ-020 SHALL, when GAROA_CAL_FAST_EN is undefined, use the serial 8-iteration datapath of REQ-012/013; results SHALL be identical in both builds.

Structure
REQ-021 SHALL have package garoa_cal_pkg holding GF_W=8, DEFAULT_POLY=8'h1B, the FSM state typedef (IDLE, RUN) and a function gf_xtime.
REQ-022 SHALL have one sub-module gf_xtime (8-bit in/out, POLY parameter), instantiated in the serial loop or 8x in the fast build.

Verification
REQ-023 SHALL show x=8'h56, y=8'h12, start pulse -> done after 9 cycles (1 if FAST), d=8'hBB.
REQ-024 SHALL show x=8'h46, y=8'h4C -> d=8'h35; then x=8'h02, y=8'h4C -> d=8'h98.
REQ-025 SHALL show x=8'h13, y=8'h5C -> d=8'h53; then x=8'h53, y=8'hCA -> d=8'h01 (inverse pair).
REQ-026 SHALL show start again 3 cycles into an operation with x=8'hFF -> ignored; the original result is delivered and only one done pulse occurs.
REQ-027 SHALL show rst=1 at cycle 4 of an operation -> busy=0, done never pulses, d=8'h00; the next start with x=8'h00, y=8'hAB -> d=8'h00.
REQ-028 SHALL show back-to-back start on the done cycle with x=8'h01, y=8'hE5 -> d=8'hE5, no idle cycle required.
